// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A control logic.
//   pic_init_state_t : initialization sequencer states
//   ICW1_* / OCW3_*  : bit positions within the written byte
//   ICW1_SEL / OCW_SEL : D4 marks ICW1 (A0=0); D3 splits OCW2/OCW3
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_init_state_t;

  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned ICW1_SEL  = 4;
  localparam int unsigned OCW_SEL   = 3;
  localparam int unsigned OCW3_RIS  = 0;
  localparam int unsigned OCW3_RR   = 1;
  localparam int unsigned OCW3_P    = 2;
  localparam int unsigned OCW3_SMM  = 5;
  localparam int unsigned OCW3_ESMM = 6;

endpackage

// File: rtl/pic_sync.sv
// N-flop synchronizer for an asynchronous active-low pin.
//   clk, rst_n : clock, async active-low reset (flops reset to 1 = pin idle)
//   d          : asynchronous input
//   q          : synchronized output, N clocks after d
module pic_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N:0] chain;

  assign chain[0] = d;
  assign q        = chain[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain[N:1] <= '1;
    else        chain[N:1] <= chain[N-1:0];
  end

endmodule

// File: rtl/pic_control_logic.sv
// 8259A read/write control and initialization sequencer.
//   cs_n/rd_n/wr_n/a0 : CPU pins (async strobes synchronized here)
//   data_in           : byte written by the data bus buffer
//   irr/isr           : readback sources
//   buf_rd/buf_wr     : active-high strobes to the data bus buffer
//   rd_data           : registered internal read bus
//   init_done, ltim/sngl/ic4, vector_base, icw3, icw4 : ICW configuration
//   imr, ocw2_data/ocw2_valid, read_isr, smm, poll_cmd : OCW results
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic       buf_rd,
  output logic       buf_wr,
  output logic [7:0] rd_data,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic [4:0] icw4,
  output logic [7:0] imr,
  output logic [7:0] ocw2_data,
  output logic       ocw2_valid,
  output logic       read_isr,
  output logic       smm,
  output logic       poll_cmd
);

  logic cs_q, rd_q, wr_q;
  logic cs_s, rd_s, wr_s;

  pic_sync #(.N(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_q));
  pic_sync #(.N(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst_n(rst_n), .d(rd_n), .q(rd_q));
  pic_sync #(.N(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst_n(rst_n), .d(wr_n), .q(wr_q));

  assign cs_s = ~cs_q;
  assign rd_s = ~rd_q;
  assign wr_s = ~wr_q;

  logic       wr_act, wr_act_q, commit;
  logic       a0_q;
  logic [7:0] data_q;

  assign wr_act = wr_s & cs_s & ~rd_s;
  assign buf_wr = wr_act;
  assign buf_rd = rd_s & cs_s & ~wr_s;
  // Falling edge of the write window commits; a simultaneous rd blocks it.
  assign commit = wr_act_q & ~wr_act & ~(rd_s & wr_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_q <= 1'b0;
      a0_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_act_q <= wr_act;
      if (wr_act) begin
        a0_q   <= a0;
        data_q <= data_in;
      end
    end
  end

  pic_init_state_t state_q, state_d;
  logic ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, ld_ocw2, ld_ocw3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNINIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_icw1 = 1'b0;
    ld_icw2 = 1'b0;
    ld_icw3 = 1'b0;
    ld_icw4 = 1'b0;
    ld_ocw1 = 1'b0;
    ld_ocw2 = 1'b0;
    ld_ocw3 = 1'b0;
    if (commit) begin
      if (!a0_q && data_q[ICW1_SEL]) begin
        ld_icw1 = 1'b1;
        state_d = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (a0_q) begin
            ld_icw2 = 1'b1;
            state_d = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: if (a0_q) begin
            ld_icw3 = 1'b1;
            state_d = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (a0_q) begin
            ld_icw4 = 1'b1;
            state_d = READY;
          end
          READY: begin
            if (a0_q)                 ld_ocw1 = 1'b1;
            else if (!data_q[OCW_SEL]) ld_ocw2 = 1'b1;
            else                      ld_ocw3 = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done   <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      ic4         <= 1'b0;
      vector_base <= '0;
      icw3        <= '0;
      icw4        <= '0;
      imr         <= '0;
      ocw2_data   <= '0;
      ocw2_valid  <= 1'b0;
      read_isr    <= 1'b0;
      smm         <= 1'b0;
      poll_cmd    <= 1'b0;
      rd_data     <= '0;
    end else begin
      ocw2_valid <= ld_ocw2;
      poll_cmd   <= ld_ocw3 & data_q[OCW3_P];
      if (ld_icw1) begin
        ltim      <= data_q[ICW1_LTIM];
        sngl      <= data_q[ICW1_SNGL];
        ic4       <= data_q[ICW1_IC4];
        imr       <= '0;
        icw4      <= '0;
        read_isr  <= 1'b0;
        smm       <= 1'b0;
        init_done <= 1'b0;
      end
      if (state_d == READY && state_q != READY) init_done <= 1'b1;
      if (ld_icw2) vector_base <= data_q[7:3];
      if (ld_icw3) icw3 <= data_q;
      if (ld_icw4) icw4 <= data_q[4:0];
      if (ld_ocw1) imr <= data_q;
      if (ld_ocw2) ocw2_data <= data_q;
      if (ld_ocw3) begin
        if (data_q[OCW3_RR])   read_isr <= data_q[OCW3_RIS];
        if (data_q[OCW3_ESMM]) smm      <= data_q[OCW3_SMM];
      end
      if (buf_rd) rd_data <= a0 ? imr : (read_isr ? isr : irr);
      else        rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_pic_control_logic.sv
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] data_in = '0, irr = 8'h3C, isr = 8'hC1;
  logic       buf_rd, buf_wr, init_done, ltim, sngl, ic4;
  logic       ocw2_valid, read_isr, smm, poll_cmd;
  logic [7:0] rd_data, icw3, imr, ocw2_data;
  logic [4:0] vector_base, icw4;

  pic_control_logic #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .data_in(data_in), .irr(irr), .isr(isr), .buf_rd(buf_rd), .buf_wr(buf_wr),
    .rd_data(rd_data), .init_done(init_done), .ltim(ltim), .sngl(sngl), .ic4(ic4),
    .vector_base(vector_base), .icw3(icw3), .icw4(icw4), .imr(imr),
    .ocw2_data(ocw2_data), .ocw2_valid(ocw2_valid), .read_isr(read_isr),
    .smm(smm), .poll_cmd(poll_cmd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ocw2_cnt = 0;
  int poll_cnt = 0;

  always @(posedge clk) begin
    if (ocw2_valid === 1'b1) ocw2_cnt <= ocw2_cnt + 1;
    if (poll_cmd === 1'b1)   poll_cnt <= poll_cnt + 1;
  end

  // Reference model: transaction-level view of the programming sequence.
  bit         m_started;
  int         m_pending[$];   // ICW numbers still expected, in order
  bit         m_ltim, m_sngl, m_ic4, m_risr, m_smm, m_done;
  logic [4:0] m_vb, m_icw4;
  logic [7:0] m_icw3, m_imr, m_ocw2;
  int         m_ocw2_cnt, m_poll_cnt;

  function automatic void model_reset();
    m_started = 0; m_pending.delete();
    m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_risr = 0; m_smm = 0; m_done = 0;
    m_vb = '0; m_icw4 = '0; m_icw3 = '0; m_imr = '0; m_ocw2 = '0;
  endfunction

  function automatic void model_write(input bit a, input logic [7:0] d);
    int n;
    if (!a && d[4]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_imr = '0; m_icw4 = '0; m_risr = 0; m_smm = 0; m_done = 0;
      m_started = 1;
      m_pending.delete();
      m_pending.push_back(2);
      if (!d[1]) m_pending.push_back(3);
      if (d[0])  m_pending.push_back(4);
    end else if (m_started && m_pending.size() > 0) begin
      if (a) begin
        n = m_pending.pop_front();
        if (n == 2)      m_vb   = d[7:3];
        else if (n == 3) m_icw3 = d;
        else             m_icw4 = d[4:0];
        if (m_pending.size() == 0) m_done = 1;
      end
    end else if (m_started) begin
      if (a) m_imr = d;
      else if (!d[3]) begin
        m_ocw2 = d;
        m_ocw2_cnt++;
      end else begin
        if (d[1]) m_risr = d[0];
        if (d[6]) m_smm  = d[5];
        if (d[2]) m_poll_cnt++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("ltim", ltim, m_ltim);
    chk("sngl", sngl, m_sngl);
    chk("ic4", ic4, m_ic4);
    chk("vector_base", vector_base, m_vb);
    chk("icw3", icw3, m_icw3);
    chk("icw4", icw4, m_icw4);
    chk("imr", imr, m_imr);
    chk("ocw2_data", ocw2_data, m_ocw2);
    chk("read_isr", read_isr, m_risr);
    chk("smm", smm, m_smm);
    chk("init_done", init_done, m_done);
    chk("ocw2_pulses", ocw2_cnt, m_ocw2_cnt);
    chk("poll_pulses", poll_cnt, m_poll_cnt);
  endtask

  // One CPU write; early_cs ends the cycle by raising cs_n while wr_n stays low.
  task automatic cpu_write(input bit a, input logic [7:0] d, input bit early_cs);
    int p_ocw2, p_poll;
    @(negedge clk);
    a0 = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1 chk("buf_wr_early", buf_wr, 0);
    @(posedge clk); #1 chk("buf_wr_rise", buf_wr, 1);
    @(negedge clk);
    cs_n = 1'b1;
    if (!early_cs) wr_n = 1'b1;
    p_ocw2 = m_ocw2_cnt; p_poll = m_poll_cnt;
    model_write(a, d);
    repeat (2) @(posedge clk);
    #1 chk("buf_wr_fall", buf_wr, 0);
    @(posedge clk);
    #1 chk("ocw2_valid_t", ocw2_valid, m_ocw2_cnt != p_ocw2);
    chk("poll_cmd_t", poll_cmd, m_poll_cnt != p_poll);
    @(negedge clk); wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all();
  endtask

  task automatic cpu_read(input bit a);
    logic [7:0] exp;
    @(negedge clk);
    a0 = a; cs_n = 1'b0; rd_n = 1'b0;
    exp = a ? m_imr : (m_risr ? isr : irr);
    repeat (3) @(posedge clk);
    #1 chk("buf_rd", buf_rd, 1);
    chk("rd_data", rd_data, exp);
    @(negedge clk); cs_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("buf_rd_off", buf_rd, 0);
    chk("rd_data_idle", rd_data, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int op;
    m_ocw2_cnt = 0; m_poll_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_buf", {buf_rd, buf_wr}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Writes before ICW1 are ignored.
    cpu_write(1'b1, 8'hFF, 1'b0);
    cpu_write(1'b0, 8'h20, 1'b0);

    // Cascade init with ICW4.
    cpu_write(1'b0, 8'h11, 1'b0);
    cpu_write(1'b1, 8'h48, 1'b0);
    cpu_write(1'b1, 8'h04, 1'b1);
    chk("done_before_icw4", init_done, 0);
    cpu_write(1'b1, 8'h01, 1'b0);
    chk("vb_09", vector_base, 5'h09);
    chk("init_done_4th", init_done, 1);

    // OCW2/OCW3.
    cpu_write(1'b0, 8'h20, 1'b0);
    cpu_write(1'b0, 8'h0B, 1'b0);
    chk("read_isr_set", read_isr, 1);
    cpu_read(1'b0);
    cpu_write(1'b0, 8'h0C, 1'b0);
    cpu_write(1'b0, 8'h68, 1'b0);
    chk("smm_set", smm, 1);

    // Single mode, no ICW4, then OCW1.
    cpu_write(1'b0, 8'h12, 1'b0);
    cpu_write(1'b1, 8'h20, 1'b0);
    chk("single_done", init_done, 1);
    cpu_write(1'b1, 8'hA5, 1'b0);
    chk("imr_a5", imr, 8'hA5);
    cpu_read(1'b1);

    // ICW1 mid-sequence restarts at ICW2.
    cpu_write(1'b0, 8'h11, 1'b0);
    cpu_write(1'b1, 8'h48, 1'b0);
    cpu_write(1'b0, 8'h19, 1'b0);
    cpu_write(1'b1, 8'h80, 1'b0);
    chk("restart_vb", vector_base, 5'h10);

    // Reset during WAIT_ICW3 with a write in flight.
    @(negedge clk); a0 = 1'b1; data_in = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_buf_wr", buf_wr, 0);
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all();
    cpu_write(1'b1, 8'h5A, 1'b0);

    // rd_n and wr_n together: no strobes, no commit of what would be ICW1.
    @(negedge clk); a0 = 1'b0; data_in = 8'h13; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("contend_strobes", {buf_rd, buf_wr}, 0);
    @(negedge clk); cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all();

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 11);
      d  = 8'($urandom);
      if (op == 0)      cpu_write(1'b0, d | 8'h10, $urandom_range(0, 1) == 1);
      else if (op <= 5) cpu_write(1'b1, d, $urandom_range(0, 1) == 1);
      else if (op <= 8) cpu_write(1'b0, d & 8'hEF, $urandom_range(0, 1) == 1);
      else if (op <= 10) cpu_read($urandom_range(0, 1) == 1);
      else begin
        irr = 8'($urandom);
        isr = 8'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Read/write control and initialization sequencer of the 8259A PIC, sitting directly downstream of the data bus buffer. It synchronizes the CPU strobes, decodes CS/A0/D4/D3 into ICW1–ICW4 and OCW1–OCW3, and holds the resulting configuration registers. It drives the active-high `rd`/`wr` strobes of the data bus buffer and muxes IRR/ISR/IMR onto the internal read bus.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchronizer depth on `cs_n`, `rd_n`, `wr_n`.

Ports. One clock; reset is asynchronous and active-low.
- `clk` input 1: block clock.
- `rst_n` input 1: asynchronous active-low reset.
- `cs_n`, `rd_n`, `wr_n` input 1 each: CPU pins, asynchronous, active-low.
- `a0` input 1: CPU address bit.
- `data_in` input 8: internal bus written by the buffer.
- `irr`, `isr` input 8 each: request and in-service registers for readback.
- `buf_rd`, `buf_wr` output 1 each: active-high strobes to the data bus buffer.
- `rd_data` output 8: internal read bus value.
- `init_done` output 1: set when the ICW sequence completes.
- `ltim`, `sngl`, `ic4` output 1 each: ICW1 bits D3, D1, D0.
- `vector_base` output 5: ICW2 D7:D3.
- `icw3` output 8: cascade byte.
- `icw4` output 5: ICW4 D4:D0 (SFNM, BUF, M/S, AEOI, µPM).
- `imr` output 8: interrupt mask (OCW1).
- `ocw2_data` output 8 and `ocw2_valid` output 1: OCW2 byte plus a 1-cycle pulse.
- `read_isr` output 1: readback select (0 = IRR, 1 = ISR).
- `smm` output 1: special mask mode.
- `poll_cmd` output 1: 1-cycle pulse on OCW3 with P=1.

## Operation
- Synchronized signals: `cs_s`, `rd_s`, `wr_s` (active-high after inversion).
- Write phase:
  - `wr_act = wr_s & cs_s & ~rd_s`.
  - While `wr_act` is high, `a0` and `data_in` are registered every cycle.
  - A commit occurs on the cycle `wr_act` falls 1→0, using the last registered values.
- `buf_wr = wr_act`.
- `buf_rd = rd_s & cs_s & ~wr_s`.
- `rd_data` while `buf_rd`: A0=1 → `imr`; A0=0 → `read_isr ? isr : irr`. Otherwise 0x00.
- If `rd_s` and `wr_s` are high together: no strobe and no commit.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- Commit decode, in priority order:
  - **A0=0, D4=1 (ICW1), any state.** Store `ltim`/`sngl`/`ic4`. Clear `imr`, `icw4`, `read_isr` and `smm`; clear `init_done`. Go to WAIT_ICW2.
  - **WAIT_ICW2, A0=1.** Store `vector_base`. Next state: `~sngl` → WAIT_ICW3; else `ic4` → WAIT_ICW4; else READY.
  - **WAIT_ICW3, A0=1.** Store `icw3`. Next state: `ic4` → WAIT_ICW4, else READY.
  - **WAIT_ICW4, A0=1.** Store `icw4`. Go to READY.
  - **READY, A0=1 (OCW1).** `imr <= data`.
  - **READY, A0=0, D4:D3=00 (OCW2).** `ocw2_data <= data` and pulse `ocw2_valid`.
  - **READY, A0=0, D4:D3=01 (OCW3).**
    - If D1: `read_isr <= D0`.
    - If D6: `smm <= D5`.
    - If D2: pulse `poll_cmd`.
  - Any other commit in UNINIT or WAIT_*: ignored, state unchanged.
- `init_done` is set on entry to READY.

## Timing
- Reset values:
  - State UNINIT.
  - All register outputs 0, including `vector_base`, `icw3`, `icw4`, `imr`, `ocw2_data`, `read_isr`, `smm` and `init_done`.
  - Pulses low, strobes low, `rd_data` 0x00.
- Strobe latency: `buf_wr`/`buf_rd` rise `SYNC_STAGES` clocks after the pin edge.
- Commit latency: register outputs update `SYNC_STAGES`+1 clocks after the `wr_n` rising edge.
- `ocw2_valid`/`poll_cmd` are high for exactly that commit cycle.
- `cs_n` rising together with `wr_n` still commits, because the qualifying data was latched earlier.
- `cs_n` rising while `wr_n` is still low ends `wr_act` and therefore commits.
- `rd_data` is registered: valid 1 clock after `buf_rd` rises, and 0x00 one clock after it falls.
- `rst_n` low mid-sequence: immediate return to reset values. The in-progress write is discarded.

## Structure
- Package `pic_pkg`:
  - State enum `pic_init_state_t`.
  - ICW1/OCW bit-position constants (`ICW1_IC4`, `ICW1_SNGL`, `ICW1_LTIM`, `OCW3_RR`, `OCW3_RIS`, `OCW3_P`, `OCW3_ESMM`, `OCW3_SMM`).
- Sub-module `pic_sync`: parameterized N-flop synchronizer with reset value 1 for the active-low pins. It is instantiated three times.

## Test plan
- **Full cascade init.** ICW1=0x11, ICW2=0x48, ICW3=0x04, ICW4=0x01 → `vector_base`=0x09, `icw3`=0x04, `icw4`=0x01; `init_done` rises after the 4th commit.
- **Single, no ICW4.** ICW1=0x12, then ICW2=0x20 → READY after 2 writes; `icw4`=0; a following A0=1 write of 0xA5 sets `imr`=0xA5.
- **OCW2/OCW3 in READY.**
  - OCW2 0x20 → `ocw2_valid` 1-cycle pulse, `ocw2_data`=0x20.
  - OCW3 0x0B → `read_isr`=1; A0=0 read returns `isr`.
  - OCW3 0x0C → `poll_cmd` pulse.
  - OCW3 0x68 → `smm`=1.
- **Re-init and ignored writes.**
  - Writes before ICW1 (A0=1 0xFF; OCW2 0x20) → no change and no pulse.
  - ICW1 mid-sequence (after ICW2) → restarts WAIT_ICW2 and `imr` clears.
- **Reset and contention.**
  - `rst_n` asserted during WAIT_ICW3 → all outputs return to 0 and state is UNINIT.
  - `rd_n` and `wr_n` low simultaneously with `cs_n` low → no strobes and no commit.
